// File: rtl/onc_16_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// onc_16_mem_arb_pkg
// Shared definitions for the ONC-16 unified-memory arbiter:
//   - ONC_DATA_W   : native ONC-16 word width, default for address and data.
//   - ARB_MEM_LAT  : default RAM read latency (cycles after the mem_en cycle).
//   - ARB_ST_W     : arbiter FSM state width, states ARB_IDLE .. ARB_ACK.
//   - ARB_PORT_I / ARB_PORT_D : port identifiers (fetch / data).
//   - ARB_CNT_W    : width of the WAIT-phase counter (covers MEM_LAT 1..4).
// Optional build macro used by the arbiter: ONC_16_ARB_FETCH_PRIO_EN.
// -----------------------------------------------------------------------------
package onc_16_mem_arb_pkg;

    localparam int ONC_DATA_W  = 16;
    localparam int ARB_MEM_LAT = 1;
    localparam int ARB_ST_W    = 2;
    localparam int ARB_CNT_W   = 2;

    typedef enum logic [ARB_ST_W-1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ACK   = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_PORT_I = 1'b0,
        ARB_PORT_D = 1'b1
    } arb_port_e;

    // One-hot grant encoding: bit 0 = fetch, bit 1 = data.
    function automatic arb_port_e grant_to_port(input logic [1:0] grant);
        return grant[1] ? ARB_PORT_D : ARB_PORT_I;
    endfunction

endpackage

// File: rtl/onc_16_rr_arb2.sv
// -----------------------------------------------------------------------------
// onc_16_rr_arb2
// Two-requester arbiter for the ONC-16 memory arbiter. Produces a one-hot
// grant from the fetch and data requests; on a tie the port that was not
// served last wins. The "last served" register is updated when the parent
// FSM accepts a grant. Reset leaves rr_last = data so fetch wins the first tie.
//
// Build option: ONC_16_ARB_FETCH_PRIO_EN - ties always go to fetch and the
// last-served register is not needed.
//
// Ports:
//   clock   in  system clock, rising edge
//   n_rst   in  synchronous active-low reset
//   i_req   in  fetch request
//   d_req   in  data request
//   accept  in  parent has taken the current grant this cycle
//   grant   out one-hot grant (bit 0 fetch, bit 1 data), combinational
// -----------------------------------------------------------------------------
module onc_16_rr_arb2
    import onc_16_mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       n_rst,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef ONC_16_ARB_FETCH_PRIO_EN

    // Fixed priority: fetch whenever it asks, data only when fetch is idle.
    always_comb begin
        grant = 2'b00;
        if (i_req) begin
            grant = 2'b01;
        end else if (d_req) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

`else

    arb_port_e rr_last_r;

    // Round-robin tie-break: the port that was not served last wins a tie.
    always_comb begin
        grant = 2'b00;
        if (i_req && d_req) begin
            if (rr_last_r == ARB_PORT_D) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else if (i_req) begin
            grant = 2'b01;
        end else if (d_req) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

    // Remember which port was granted last, updated only on an accepted grant.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            rr_last_r <= ARB_PORT_D;
        end else if (accept && (grant != 2'b00)) begin
            rr_last_r <= grant_to_port(grant);
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

`endif

endmodule

// File: rtl/onc_16_mem_arb.sv
// -----------------------------------------------------------------------------
// onc_16_mem_arb
// Arbitrates one single-port synchronous RAM (program + data) between the
// ONC-16 instruction-fetch port and its data port. One transaction at a time:
//   IDLE -> ISSUE (1 cycle, mem_en) -> WAIT (MEM_LAT cycles) -> ACK -> IDLE
// Read data is captured from mem_rdata on the last WAIT cycle and presented
// with a one-cycle ack pulse on the granted port. All outputs are registered.
//
// Build option: ONC_16_ARB_FETCH_PRIO_EN - fetch always wins a tie (handled
// in onc_16_rr_arb2); default is round-robin.
//
// Parameters: ADDR_W, DATA_W (default 16), MEM_LAT (1..4, default 1).
// Ports:
//   clock, n_rst               clock (rising edge), synchronous active-low reset
//   i_req, i_addr              fetch request (level) and address
//   i_ack, i_rdata             fetch completion pulse and fetched word
//   d_req, d_we, d_addr, d_wdata  data request, write flag, address, write data
//   d_ack, d_rdata             data completion pulse and read data
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata  RAM interface
//   busy                       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module onc_16_mem_arb
    import onc_16_mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ONC_DATA_W,
    parameter int DATA_W  = ONC_DATA_W,
    parameter int MEM_LAT = ARB_MEM_LAT
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Counter value reached on the final WAIT cycle.
    localparam logic [ARB_CNT_W-1:0] LAT_LAST = ARB_CNT_W'(MEM_LAT - 1);

    arb_state_e           state_r;
    arb_state_e           state_s;
    logic [ARB_CNT_W-1:0] cnt_r;
    arb_port_e            port_r;
    logic                 we_r;

    logic [1:0]           grant_s;
    logic                 accept_s;
    logic                 last_wait_s;
    logic                 sel_we_s;
    logic [ADDR_W-1:0]    sel_addr_s;
    logic [DATA_W-1:0]    sel_wdata_s;

    logic                 i_ack_r;
    logic                 d_ack_r;
    logic [DATA_W-1:0]    i_rdata_r;
    logic [DATA_W-1:0]    d_rdata_r;
    logic                 mem_en_r;
    logic                 mem_we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [DATA_W-1:0]    mem_wdata_r;
    logic                 busy_r;

    onc_16_rr_arb2 u_rr_arb2 (
        .clock  (clock),
        .n_rst  (n_rst),
        .i_req  (i_req),
        .d_req  (d_req),
        .accept (accept_s),
        .grant  (grant_s)
    );

    assign last_wait_s = (state_r == ARB_WAIT) && (cnt_r == LAT_LAST);

    // Next-state logic; a grant is only taken while IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (grant_s != 2'b00) begin
                    state_s  = ARB_ISSUE;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                state_s = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (last_wait_s) begin
                    state_s = ARB_ACK;
                end else begin
                    state_s = ARB_WAIT;
                end
            end
            ARB_ACK: begin
                state_s = ARB_IDLE;
            end
            default: begin
                state_s = ARB_IDLE;
            end
        endcase
    end

    // Winner's request fields; a fetch is always a read with zero write data.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = i_addr;
        sel_wdata_s = {DATA_W{1'b0}};
        if (grant_s[1]) begin
            sel_we_s    = d_we;
            sel_addr_s  = d_addr;
            sel_wdata_s = d_wdata;
        end else begin
            sel_we_s    = 1'b0;
            sel_addr_s  = i_addr;
            sel_wdata_s = {DATA_W{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // WAIT-phase counter: counts cycles spent in WAIT, zero elsewhere.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            cnt_r <= {ARB_CNT_W{1'b0}};
        end else if ((state_r == ARB_WAIT) && (state_s == ARB_WAIT)) begin
            cnt_r <= cnt_r + ARB_CNT_W'(1);
        end else begin
            cnt_r <= {ARB_CNT_W{1'b0}};
        end
    end

    // Latch which port owns the transaction and whether it is a write.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            port_r <= ARB_PORT_I;
            we_r   <= 1'b0;
        end else if (accept_s) begin
            port_r <= grant_to_port(grant_s);
            we_r   <= sel_we_s;
        end else begin
            port_r <= port_r;
            we_r   <= we_r;
        end
    end

    // RAM strobe for exactly the ISSUE cycle; address/data held afterwards.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= sel_we_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
        end else begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
        end
    end

    // Capture read data on the last WAIT cycle and raise the owner's ack for ACK.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
            i_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r <= {DATA_W{1'b0}};
        end else if (last_wait_s) begin
            i_ack_r <= (port_r == ARB_PORT_I);
            d_ack_r <= (port_r == ARB_PORT_D);
            if (port_r == ARB_PORT_I) begin
                i_rdata_r <= mem_rdata;
                d_rdata_r <= d_rdata_r;
            end else if (!we_r) begin
                i_rdata_r <= i_rdata_r;
                d_rdata_r <= mem_rdata;
            end else begin
                // Data write: both read registers keep their values.
                i_rdata_r <= i_rdata_r;
                d_rdata_r <= d_rdata_r;
            end
        end else begin
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
            i_rdata_r <= i_rdata_r;
            d_rdata_r <= d_rdata_r;
        end
    end

    // Busy mirrors "not IDLE" for the state being entered.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ARB_IDLE);
        end
    end

    assign i_ack     = i_ack_r;
    assign d_ack     = d_ack_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_onc_16_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_onc_16_mem_arb
// Directed bench for onc_16_mem_arb. Two instances: "a" with MEM_LAT = 1 and a
// RAM model with preload port, "b" with MEM_LAT = 3 whose RAM drives a glitch
// value on mem_rdata except in the cycle the real data is due.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// Cycle 0 is the cycle in which a request is presented to an IDLE arbiter;
// ISSUE is cycle 1, WAIT cycles 2..MEM_LAT+1, ACK cycle MEM_LAT+2.
// Honours ONC_16_ARB_FETCH_PRIO_EN for the expected contention order.
// -----------------------------------------------------------------------------
module tb_onc_16_mem_arb;

    int checks   = 0;
    int failures = 0;

    logic        clock = 1'b0;
    logic        n_rst;

    // Instance a (MEM_LAT = 1)
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, mem_en, mem_we, busy;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    // Instance b (MEM_LAT = 3)
    logic        i_req_b, d_req_b, d_we_b;
    logic [15:0] i_addr_b, d_addr_b, d_wdata_b;
    logic        i_ack_b, d_ack_b, mem_en_b, mem_we_b, busy_b;
    logic [15:0] i_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    // RAM model for instance a
    logic [15:0] ram [0:65535];
    logic [15:0] rd_q;
    logic        en_d = 1'b0;
    logic        pre_we;
    logic [15:0] pre_addr, pre_data;

    // RAM model for instance b
    logic [2:0]  en_p_b = 3'b000;
    logic [15:0] rd0_b, rd1_b, rd2_b;

    logic        exp_d;
    int          ack_idx;

    always #5 clock = ~clock;

    onc_16_mem_arb #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_a (
        .clock(clock), .n_rst(n_rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    onc_16_mem_arb #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut_b (
        .clock(clock), .n_rst(n_rst),
        .i_req(i_req_b), .i_addr(i_addr_b), .i_ack(i_ack_b), .i_rdata(i_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_ack(d_ack_b), .d_rdata(d_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
    );

    // Synchronous RAM, latency 1: data valid only in the cycle after mem_en.
    always @(posedge clock) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_en) begin
            rd_q <= ram[mem_addr];
        end
        en_d <= mem_en;
    end
    assign mem_rdata = en_d ? rd_q : 16'hDEAD;

    // Latency-3 RAM holding 0x7E81 at 0x00FF; glitch value 0x5A5A otherwise.
    always @(posedge clock) begin
        en_p_b <= {en_p_b[1:0], mem_en_b};
        if (mem_en_b) begin
            rd0_b <= (mem_addr_b == 16'h00FF) ? 16'h7E81 : 16'h0000;
        end
        rd1_b <= rd0_b;
        rd2_b <= rd1_b;
    end
    assign mem_rdata_b = en_p_b[2] ? rd2_b : 16'h5A5A;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_rst    = 1'b0;
        i_req    = 1'b1;   i_addr   = 16'h0010;
        d_req    = 1'b0;   d_we     = 1'b0;
        d_addr   = 16'h0000; d_wdata = 16'h0000;
        i_req_b  = 1'b0;   i_addr_b = 16'h0000;
        d_req_b  = 1'b0;   d_we_b   = 1'b0;
        d_addr_b = 16'h0000; d_wdata_b = 16'h0000;
        pre_we   = 1'b0;   pre_addr = 16'h0000; pre_data = 16'h0000;
        ack_idx  = 0;

        // ---- Reset held 3 cycles with i_req high; RAM preloaded meanwhile
        for (int p = 0; p < 3; p++) begin
            pre_we   = 1'b1;
            pre_addr = (p == 0) ? 16'h0010 : ((p == 1) ? 16'h0020 : 16'h0030);
            pre_data = (p == 0) ? 16'hA5C3 : ((p == 1) ? 16'h1111 : 16'h2222);
            step();
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_i_ack",  32'(i_ack),  32'd0);
            chk("rst_busy",   32'(busy),   32'd0);
        end
        pre_we = 1'b0;
        chk("rst_d_ack",    32'(d_ack),    32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_i_rdata",  32'(i_rdata),  32'd0);
        chk("rst_d_rdata",  32'(d_rdata),  32'd0);

        // ---- Release reset; i_req at 0x0010 sampled in cycle 0
        n_rst = 1'b1;
        step();   // cycle 1: ISSUE
        chk("f_issue_en",   32'(mem_en),   32'd1);
        chk("f_issue_we",   32'(mem_we),   32'd0);
        chk("f_issue_addr", 32'(mem_addr), 32'h0010);
        chk("f_issue_busy", 32'(busy),     32'd1);
        step();   // cycle 2: WAIT
        chk("f_wait_en",    32'(mem_en),   32'd0);
        chk("f_wait_ack",   32'(i_ack),    32'd0);
        step();   // cycle 3: ACK
        chk("f_ack",        32'(i_ack),    32'd1);
        chk("f_rdata",      32'(i_rdata),  32'hA5C3);
        chk("f_no_d_ack",   32'(d_ack),    32'd0);
        i_req = 1'b0;
        step();   // cycle 4: IDLE
        chk("f_ack_pulse",  32'(i_ack),    32'd0);
        chk("f_idle_busy",  32'(busy),     32'd0);

        // ---- Data write 0x1234 -> 0x8000
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h8000; d_wdata = 16'h1234;
        step();
        chk("w_issue_en",    32'(mem_en),    32'd1);
        chk("w_issue_we",    32'(mem_we),    32'd1);
        chk("w_issue_addr",  32'(mem_addr),  32'h8000);
        chk("w_issue_wdata", 32'(mem_wdata), 32'h1234);
        step();
        chk("w_wait_we",     32'(mem_we),    32'd0);
        step();
        chk("w_d_ack",       32'(d_ack),     32'd1);
        chk("w_i_ack",       32'(i_ack),     32'd0);
        chk("w_d_rdata",     32'(d_rdata),   32'd0);
        d_req = 1'b0;
        step();
        chk("w_ack_pulse",   32'(d_ack),     32'd0);

        // ---- Data read back from 0x8000
        d_req = 1'b1; d_we = 1'b0;
        step();
        chk("r_issue_we",    32'(mem_we),    32'd0);
        step();
        step();
        chk("r_d_ack",       32'(d_ack),     32'd1);
        chk("r_d_rdata",     32'(d_rdata),   32'h1234);
        chk("r_i_rdata_hold", 32'(i_rdata),  32'hA5C3);
        d_req = 1'b0;
        step();

        // ---- Contention: both held; last grant was data so fetch wins first
        i_addr = 16'h0020; d_addr = 16'h0030; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if ((k % 4) == 3) begin
`ifdef ONC_16_ARB_FETCH_PRIO_EN
                exp_d = 1'b0;
`else
                exp_d = ((ack_idx % 2) == 1);
`endif
                chk("cont_i_ack", 32'(i_ack), 32'(!exp_d));
                chk("cont_d_ack", 32'(d_ack), 32'(exp_d));
                if (exp_d) begin
                    chk("cont_d_rdata", 32'(d_rdata), 32'h2222);
                end else begin
                    chk("cont_i_rdata", 32'(i_rdata), 32'h1111);
                end
                ack_idx++;
            end else begin
                chk("cont_i_quiet", 32'(i_ack), 32'd0);
                chk("cont_d_quiet", 32'(d_ack), 32'd0);
            end
            if (k == 15) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        chk("cont_end_busy", 32'(busy), 32'd0);

        // ---- Mid-transaction reset during WAIT
        i_addr = 16'h0010; i_req = 1'b1;
        step();   // ISSUE
        step();   // WAIT
        chk("mr_wait_busy", 32'(busy), 32'd1);
        n_rst = 1'b0;
        step();   // reset applied at end of WAIT
        chk("mr_busy",    32'(busy),    32'd0);
        chk("mr_no_ack",  32'(i_ack),   32'd0);
        chk("mr_mem_en",  32'(mem_en),  32'd0);
        chk("mr_i_rdata", 32'(i_rdata), 32'd0);
        n_rst = 1'b1;
        step();   // fresh request sampled previous cycle -> ISSUE
        chk("mr_no_ack2", 32'(i_ack),   32'd0);
        chk("mr_re_en",   32'(mem_en),  32'd1);
        step();
        step();
        chk("mr_re_ack",  32'(i_ack),   32'd1);
        chk("mr_re_data", 32'(i_rdata), 32'hA5C3);
        i_req = 1'b0;
        step();

        // ---- MEM_LAT = 3 instance: read 0x00FF, glitch ignored
        i_addr_b = 16'h00FF; i_req_b = 1'b1;
        step();   // cycle 1: ISSUE
        chk("l3_issue_en",   32'(mem_en_b),   32'd1);
        chk("l3_issue_addr", 32'(mem_addr_b), 32'h00FF);
        for (int c = 2; c <= 4; c++) begin
            step();   // WAIT cycles 2..4
            chk("l3_wait_ack",  32'(i_ack_b), 32'd0);
            chk("l3_wait_busy", 32'(busy_b),  32'd1);
            chk("l3_wait_en",   32'(mem_en_b), 32'd0);
        end
        step();   // cycle 5: ACK
        chk("l3_ack",   32'(i_ack_b),   32'd1);
        chk("l3_rdata", 32'(i_rdata_b), 32'h7E81);
        chk("l3_d_ack", 32'(d_ack_b),   32'd0);
        i_req_b = 1'b0;
        step();
        chk("l3_ack_pulse", 32'(i_ack_b), 32'd0);
        chk("l3_idle_busy", 32'(busy_b),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
